cover_event_sched: RTL and testbench
====================================

// Module: cover_event_sched
// PURPOSE
//  Collects per-point cover hits (valid pulses from many coverage points) and
//  serializes them onto a single reporting channel, one cover index per beat.
//  Sits between a bank of coverage points and the single sim-side reporter,
//  so the reporter sees at most one event per cycle with valid/ready flow control.
//  Coalesces repeat hits while pending; optional report-once filtering per point.
// PARAMETERS
//  NUM_REQ      8      number of coverage points served (>=2)
//  IDX_W        16     width of a cover index (must hold COVER_TOTAL-1)
//  COVER_TOTAL  10906  total cover points in design; indices >= this are illegal
//  ONCE_ONLY    1      1: a point is reported at most once until clear_seen
//  CNT_W        32     width of merged-hit counter
// PORTS
//  clock       in   1              design clock
//  reset       in   1              synchronous, active-high
//  enable      in   1              accept new hits when high
//  req_valid   in   NUM_REQ        per-point hit pulse
//  req_index   in   NUM_REQ*IDX_W  per-point cover index, slot i at [i*IDX_W +: IDX_W]
//  clear_seen  in   1              clear report-once bitmap
//  out_valid   out  1              report beat valid
//  out_index   out  IDX_W          cover index of reported point
//  out_ready   in   1              reporter accepts beat
//  idle        out  1              no pending hits and no beat held
//  merged_cnt  out  CNT_W          hits coalesced into an already-pending point
// BEHAVIOUR
//  - Reset: pending=0, seen=0, idx_q=0, rr_ptr=0, out_valid=0, out_index=0,
//    merged_cnt=0; idle=1.
//  - Accept: hit i accepted at edge if enable && req_valid[i] && !(ONCE_ONLY && seen[i]);
//    sets pending[i], captures req_index slot i into idx_q[i].
//  - Merge: accepted hit on a point already pending and not granted this cycle
//    -> merged_cnt += 1 per such point (popcount); saturates at all-ones, never wraps.
//  - Slot free = !out_valid || out_ready. When free and any pending: round-robin
//    grant from rr_ptr upward (wrap at NUM_REQ); out_valid<=1, out_index<=idx_q[g],
//    pending[g] cleared, rr_ptr<=(g+1)%NUM_REQ, seen[g]<=1 when ONCE_ONLY.
//  - Free with nothing pending -> out_valid<=0. Not free -> out_valid/out_index hold;
//    no retraction or change while out_valid && !out_ready.
//  - Back-to-back: with out_ready=1, one beat per cycle sustained.
//  - Latency: req_valid in cycle t -> out_valid in cycle t+2 (pending empty, ready high).
//  - Same cycle grant of g and new accepted hit on g: set wins, pending[g] stays 1
//    (re-reported later); with ONCE_ONLY, hit on g is rejected from the next cycle.
//  - Hits are not merge-counted in that same-cycle case.
//  - clear_seen: seen<=0 at edge; wins over a same-cycle grant setting seen.
//    Does not touch pending.
//  - enable low: no new accepts; existing pending still drains.
//  - idle = !out_valid && (pending==0), combinational from registers.
//  - Reset mid-operation drops all pending/held beats; no beat emitted in reset cycle.
//  - Sim-only assertion: out_index < COVER_TOTAL whenever out_valid.
//  - Sim-only assertion: out_valid/out_index stable while out_valid && !out_ready.
// STRUCTURE
//  - Package cover_sched_pkg:
//    - IDX_W default; typedef cover_idx_t; COVER_TOTAL constant.
//    - function rr_next(ptr, NUM_REQ).
//  - Sub-module cover_rr_arbiter:
//    - inputs: req vector, rr_ptr.
//    - outputs: one-hot grant, grant index, any.
//    - purely combinational.
//  - Top holds pending/seen/idx_q, rr_ptr, output register, merged counter.
// TESTING
//  1 Single hit: point 3 idx 0x0123 pulses, ready=1 -> out_valid at t+2, index 0x0123,
//    one beat; idle back to 1 afterwards.
//  2 All 8 pulse same cycle, ready=1 -> 8 beats on consecutive cycles in order 0..7;
//    repeat from rr_ptr=5 -> order 5,6,7,0..4.
//  3 Backpressure: ready=0 for 4 cycles with 2 pending -> first beat held stable;
//    ready=1 -> both drain, no loss or duplicate.
//  4 Merge: point 2 pulses 3x while stalled, ONCE_ONLY=0 -> one beat, merged_cnt=2.
//    Preload near all-ones -> saturates.
//  5 ONCE_ONLY: point 1 hit, reported, hit again -> no second beat.
//    clear_seen then hit -> reported again. Grant + clear_seen same cycle -> seen[1]=0.
//  6 Reset asserted with 4 pending and a held beat -> next cycle out_valid=0, idle=1,
//    merged_cnt=0. enable=0 hits ignored.

Source files
------------

// File: rtl/cover_sched_pkg.sv
// Shared types and helpers for the cover event scheduler.
// No logic of its own; consumed by the arbiter and the scheduler top.
// Index width and cover total here are defaults; the top may override them.
package cover_sched_pkg;

    localparam int IDX_W_DEF       = 16;
    localparam int COVER_TOTAL_DEF = 10906;

    typedef logic [IDX_W_DEF-1:0] cover_idx_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/cover_rr_arbiter.sv
// Round-robin pick among pending cover points, searching upward from rr_ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller decides whether the grant is used.
module cover_rr_arbiter
    import cover_sched_pkg::*;
#(
    parameter int N     = 8,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = int'(rr_ptr);
        for (int k = 0; k < N; k++) begin
            if (!any && req[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = PTR_W'(j);
            end
            j = rr_next(j, N);
        end
    end

endmodule

// File: rtl/cover_event_sched.sv
// Serializes per-point cover hits onto one valid/ready reporting channel.
// Latency: hit in cycle t reaches out_valid in cycle t+2 when idle and ready.
// Backpressure: held beat stays stable while out_ready is low; hits keep pending.
module cover_event_sched
    import cover_sched_pkg::*;
#(
    parameter int NUM_REQ     = 8,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int COVER_TOTAL = COVER_TOTAL_DEF,
    parameter bit ONCE_ONLY   = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*IDX_W-1:0] req_index,
    input  logic                     clear_seen,
    output logic                     out_valid,
    output logic [IDX_W-1:0]         out_index,
    input  logic                     out_ready,
    output logic                     idle,
    output logic [CNT_W-1:0]         merged_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int POP_W = $clog2(NUM_REQ + 1);

    logic [NUM_REQ-1:0] pending, seen, acc, gnt, gnt_mask, merge;
    logic [IDX_W-1:0]   idx_q [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr, gidx;
    logic               any, free;
    logic [POP_W-1:0]   merge_pop;
    logic [CNT_W:0]     cnt_sum;

    cover_rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req       (pending),
        .rr_ptr    (rr_ptr),
        .grant     (gnt),
        .grant_idx (gidx),
        .any       (any)
    );

    // A point granted this edge and hit again stays pending; that is not a merge.
    always_comb begin
        free      = !out_valid || out_ready;
        acc       = req_valid & ~(seen & {NUM_REQ{ONCE_ONLY}}) & {NUM_REQ{enable}};
        gnt_mask  = (free && any) ? gnt : '0;
        merge     = acc & pending & ~gnt_mask;
        merge_pop = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            merge_pop = merge_pop + POP_W'(merge[i]);
        end
        cnt_sum = {1'b0, merged_cnt} + (CNT_W+1)'(merge_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending    <= '0;
            seen       <= '0;
            rr_ptr     <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            merged_cnt <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            pending <= (pending & ~gnt_mask) | acc;
            if (clear_seen) begin
                seen <= '0;
            end else if (ONCE_ONLY) begin
                seen <= seen | gnt_mask;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    idx_q[i] <= req_index[i*IDX_W +: IDX_W];
                end
            end
            if (free) begin
                out_valid <= any;
                if (any) begin
                    out_index <= idx_q[gidx];
                    rr_ptr    <= PTR_W'(rr_next(int'(gidx), NUM_REQ));
                end
            end
            merged_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    assign idle = !out_valid && (pending == '0);

`ifndef SYNTHESIS
    a_idx_legal: assert property (@(posedge clock)
        out_valid |-> (32'(out_index) < COVER_TOTAL));
    a_hold_stable: assert property (@(posedge clock)
        (!reset && out_valid && !out_ready) |=> (out_valid && $stable(out_index)));
`endif

endmodule

// File: tb/tb_cover_event_sched.sv
module tb_cover_event_sched;
    localparam int N  = 8;
    localparam int IW = 16;

    logic              clock = 1'b0;
    logic              reset, enable, clear_seen, out_ready;
    logic [N-1:0]      req_valid;
    logic [N*IW-1:0]   req_index;
    logic              a_ov, b_ov, a_idle, b_idle;
    logic [IW-1:0]     a_oi, b_oi;
    logic [31:0]       a_mc;
    logic [1:0]        b_mc;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    cover_event_sched #(.NUM_REQ(N), .IDX_W(IW), .COVER_TOTAL(10906),
                        .ONCE_ONLY(1'b1), .CNT_W(32)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .req_valid(req_valid),
        .req_index(req_index), .clear_seen(clear_seen), .out_valid(a_ov),
        .out_index(a_oi), .out_ready(out_ready), .idle(a_idle), .merged_cnt(a_mc));

    cover_event_sched #(.NUM_REQ(N), .IDX_W(IW), .COVER_TOTAL(10906),
                        .ONCE_ONLY(1'b0), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .req_valid(req_valid),
        .req_index(req_index), .clear_seen(clear_seen), .out_valid(b_ov),
        .out_index(b_oi), .out_ready(out_ready), .idle(b_idle), .merged_cnt(b_mc));

    // Reference model of instance A, stepped on every edge once enabled.
    bit              model_on = 1'b0;
    bit              m_pend [N];
    bit              m_seen [N];
    int              m_idx  [N];
    int              m_rr, m_oi;
    bit              m_ov;
    longint unsigned m_mc;

    task automatic model_step();
        int g;
        bit fr;
        bit acc [N];
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_seen[i] = 0; m_idx[i] = 0;
            end
            m_rr = 0; m_ov = 0; m_oi = 0; m_mc = 0;
            return;
        end
        fr = !m_ov || out_ready;
        g  = -1;
        if (fr) begin
            for (int k = 0; k < N; k++) begin
                int j = (m_rr + k) % N;
                if (g < 0 && m_pend[j]) g = j;
            end
        end
        for (int i = 0; i < N; i++) acc[i] = enable && req_valid[i] && !m_seen[i];
        if (fr) begin
            if (g >= 0) begin
                m_ov = 1; m_oi = m_idx[g]; m_pend[g] = 0;
                m_rr = (g + 1) % N; m_seen[g] = 1;
            end else begin
                m_ov = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (m_pend[i] && i != g && m_mc < 64'hFFFF_FFFF) m_mc = m_mc + 1;
                m_pend[i] = 1;
                m_idx[i]  = int'(req_index[i*IW +: IW]);
            end
        end
        if (clear_seen) for (int i = 0; i < N; i++) m_seen[i] = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        if (model_on) model_step();
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_base(input int base);
        for (int i = 0; i < N; i++) req_index[i*IW +: IW] = IW'(base + i);
    endtask

    task automatic step(input logic [N-1:0] rv, input logic rdy, input logic cs);
        req_valid = rv; out_ready = rdy; clear_seen = cs;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b1; req_valid = '0; clear_seen = 1'b0; out_ready = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic       cs;
        logic [7:0] rv;
        int         base;
        logic       rdy;
        logic       e_ov;
        int         e_oi;
        logic       e_idle;
    } vec_t;

    vec_t tbl [$];

    initial begin
        bit any_p;
        reset = 1'b1; enable = 1'b1; clear_seen = 1'b0; out_ready = 1'b1;
        req_valid = '0; req_index = '0;

        // single hit, sequential order from rr 0, order from rr 5, grant with clear
        tbl.push_back('{0, 0, 8'h08, 'h120, 1, 0, 0,     0});
        tbl.push_back('{0, 0, 8'h00, 0,     1, 1, 'h123, 0});
        tbl.push_back('{0, 0, 8'h00, 0,     1, 0, 0,     1});
        tbl.push_back('{1, 0, 8'h00, 0,     1, 0, 0,     1});
        tbl.push_back('{0, 0, 8'hFF, 'h200, 1, 0, 0,     0});
        for (int k = 0; k < 8; k++) tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 'h200 + k, 0});
        tbl.push_back('{0, 0, 8'h00, 0,     1, 0, 0,     1});
        tbl.push_back('{0, 1, 8'h00, 0,     1, 0, 0,     1});
        tbl.push_back('{0, 0, 8'h10, 'h300, 1, 0, 0,     0});
        tbl.push_back('{0, 1, 8'h00, 0,     1, 1, 'h304, 0});
        tbl.push_back('{0, 0, 8'hFF, 'h400, 1, 0, 0,     0});
        for (int k = 0; k < 8; k++) tbl.push_back('{0, 0, 8'h00, 0, 1, 1, 'h400 + (5 + k) % 8, 0});
        tbl.push_back('{0, 0, 8'h00, 0,     1, 0, 0,     1});

        tick(); tick();
        chk("rst a_ov", a_ov, 0);     chk("rst a_oi", a_oi, 0);
        chk("rst a_idle", a_idle, 1); chk("rst a_mc", a_mc, 0);
        chk("rst b_ov", b_ov, 0);     chk("rst b_idle", b_idle, 1);
        chk("rst b_mc", b_mc, 0);
        reset = 1'b0;

        foreach (tbl[r]) begin
            reset = tbl[r].rst; clear_seen = tbl[r].cs; req_valid = tbl[r].rv;
            out_ready = tbl[r].rdy;
            set_base(tbl[r].base);
            tick();
            chk($sformatf("tbl%0d ov", r), a_ov, tbl[r].e_ov);
            if (tbl[r].e_ov) chk($sformatf("tbl%0d oi", r), a_oi, tbl[r].e_oi);
            chk($sformatf("tbl%0d idle", r), a_idle, tbl[r].e_idle);
        end

        // backpressure: two pending, first beat held for four stalled cycles
        do_reset(); set_base('h500);
        step(8'h44, 0, 0); chk("bp first ov", a_ov, 0);
        step(8'h00, 0, 0); chk("bp beat0 ov", a_ov, 1); chk("bp beat0 oi", a_oi, 'h502);
        for (int k = 0; k < 4; k++) begin
            step(8'h00, 0, 0);
            chk("bp hold ov", a_ov, 1); chk("bp hold oi", a_oi, 'h502);
        end
        step(8'h00, 1, 0); chk("bp beat1 ov", a_ov, 1); chk("bp beat1 oi", a_oi, 'h506);
        step(8'h00, 1, 0); chk("bp drain ov", a_ov, 0); chk("bp drain idle", a_idle, 1);

        // merge counting and saturation on the 2-bit counter instance
        do_reset(); set_base('h600);
        step(8'h01, 0, 0);
        step(8'h00, 0, 0); chk("mg stall oi", b_oi, 'h600);
        step(8'h04, 0, 0); step(8'h04, 0, 0); step(8'h04, 0, 0);
        chk("mg cnt b", b_mc, 2);
        step(8'h00, 1, 0); chk("mg beat ov", b_ov, 1); chk("mg beat oi", b_oi, 'h602);
        step(8'h00, 1, 0); chk("mg single beat", b_ov, 0); chk("mg idle", b_idle, 1);
        step(8'h01, 0, 0); step(8'h00, 0, 0);
        for (int k = 0; k < 5; k++) step(8'h04, 0, 0);
        chk("mg sat b", b_mc, 3);
        chk("mg once a", a_mc, 2);
        step(8'h00, 1, 0); step(8'h00, 1, 0);
        chk("mg sat drain", b_idle, 1);

        // report-once filtering and clear_seen racing a grant
        do_reset(); set_base('h110);
        step(8'h02, 1, 0); step(8'h00, 1, 0);
        chk("once beat ov", a_ov, 1); chk("once beat oi", a_oi, 'h111);
        step(8'h00, 1, 0);
        step(8'h02, 1, 0); step(8'h00, 1, 0); chk("once reject ov", a_ov, 0);
        step(8'h00, 1, 0); chk("once reject idle", a_idle, 1);
        step(8'h00, 1, 1);
        step(8'h02, 1, 0); chk("once rearm idle", a_idle, 0);
        step(8'h00, 1, 1); chk("once regrant oi", a_oi, 'h111); chk("once regrant ov", a_ov, 1);
        step(8'h02, 1, 0); chk("once clrwin idle", a_idle, 0);
        step(8'h00, 1, 0); chk("once clrwin ov", a_ov, 1);
        step(8'h00, 1, 0); chk("once end idle", a_idle, 1);

        // reset mid-operation, then enable low
        do_reset(); set_base('h700);
        step(8'h1F, 0, 0);
        step(8'h00, 0, 0); chk("mid held ov", a_ov, 1); chk("mid held oi", a_oi, 'h700);
        step(8'h02, 0, 0); chk("mid merge a", a_mc, 1);
        reset = 1'b1; req_valid = 8'hFF; out_ready = 1'b1;
        tick();
        chk("mid rst ov", a_ov, 0); chk("mid rst idle", a_idle, 1);
        chk("mid rst mc", a_mc, 0); chk("mid rst b_ov", b_ov, 0);
        reset = 1'b0; enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(8'hFF, 1, 0);
            chk("dis ov", a_ov, 0); chk("dis idle", a_idle, 1);
        end
        enable = 1'b1;

        // randomized run against the model
        model_on = 1'b1;
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            reset      = ($urandom_range(0, 499) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            clear_seen = ($urandom_range(0, 39) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 3) == 0);
                req_index[i*IW +: IW] = IW'($urandom_range(0, 10905));
            end
            tick();
            any_p = 0;
            for (int i = 0; i < N; i++) any_p |= m_pend[i];
            chk("rnd ov", a_ov, m_ov);
            if (m_ov) chk("rnd oi", a_oi, m_oi);
            chk("rnd idle", a_idle, !m_ov && !any_p);
            chk("rnd mc", a_mc, m_mc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
